dir_cmd_arbiter: RTL
====================

Name: dir_cmd_arbiter

Overview:
- Merges the two player-input sources, the on-board keypad scanner and the PS2 keyboard receiver, into one ordered stream of Pacman direction commands.
- Detects new-key events on each source and decodes them to a 2-bit direction.
- Arbitrates same-cycle events round-robin and buffers them in a small FIFO.
- The Pacman movement controller pops commands through a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- KP_UP, 5'h01, keypad code mapped to UP.
- KP_DOWN, 5'h09, keypad code mapped to DOWN.
- KP_LEFT, 5'h04, keypad code mapped to LEFT.
- KP_RIGHT, 5'h06, keypad code mapped to RIGHT.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- key_code  input  5  keypad scanner code.
- key_ready  input  1  keypad code valid (level).
- ps2_byte  input  8  PS2 receiver data byte.
- ps2_ready  input  1  PS2 byte valid (level; may stay high several cycles).
- dir_out  output  2  FIFO head direction: 0=UP, 1=DOWN, 2=LEFT, 3=RIGHT.
- dir_valid  output  1  FIFO non-empty.
- dir_ready  input  1  consumer accepts dir_out this cycle.
- last_dir  output  2  last popped direction.
- fifo_count  output  $clog2(DEPTH)+1  occupancy.
- overflow  output  1  sticky: a command was dropped.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (rst=0, async): FIFO empty, dir_valid=0, dir_out=0, last_dir=0 (UP), fifo_count=0, overflow=0, PS2 decoder IDLE, RR pointer = keypad, both pending slots empty, edge registers cleared.
- Edge detect: register key_ready and ps2_ready. An event is the first cycle the level is seen high after a low cycle. A held level yields exactly one event.
- Keypad decode: on a keypad event, key_code equal to KP_* yields that direction. Any other code is ignored.
- PS2 decoder FSM, advancing on each PS2 event:
  - IDLE: 8'hE0 -> EXT; 8'hF0 -> BRK; direction byte (WASD: 1D=UP, 1B=DOWN, 1C=LEFT, 23=RIGHT) -> emit, stay IDLE; other bytes ignored.
  - EXT: F0 -> BRK; 75=UP, 72=DOWN, 6B=LEFT, 74=RIGHT -> emit, then IDLE; other bytes -> IDLE.
  - BRK: any byte -> IDLE, no emit (release codes ignored).
- Pending slots: each source has a one-entry pending register. A decoded direction is written there in the cycle after the event. If the slot is still full, the new direction overwrites it and overflow is set.
- Arbiter: each cycle, push at most one pending slot into the FIFO.
  - Only one slot full: that slot is pushed.
  - Both full: the slot named by the RR pointer is pushed, and the pointer toggles to the other source after each two-way grant.
  - Nothing is pushed while the FIFO is full, unless a pop happens the same cycle.
- FIFO: push at the tail, pop when dir_valid && dir_ready. dir_out is registered and equals the head entry.
  - Simultaneous push and pop when full: legal, count unchanged.
  - Simultaneous push and pop when empty: not possible, since dir_valid=0.
  - Pointers wrap modulo DEPTH.
- Latency: event seen at edge N; pending written at N+1; pushed at N+2; dir_valid=1 after edge N+2 on an empty FIFO.
- Pop side: last_dir updates to the popped value at the popping edge. Popping when dir_valid=0 has no effect.
- overflow: set by a pending overwrite. clr_ovf=1 clears it. If set and clear happen in the same cycle, set wins.

Optional Feature:
- DIR_FILTER_EN defined: a pending direction equal to the most recently pushed direction is discarded instead of pushed. This suppresses key repeats. It does not set overflow. The reference value resets to "none".
- Undefined: every decoded direction is pushed.

Test Plan:
- Reset with rst=0 mid-stream holding 3 entries -> next cycle fifo_count=0, dir_valid=0, overflow=0, last_dir=0. After release, a held key_ready produces no event until it has been seen low then high again.
- key_code=5'h06, key_ready high for 10 cycles, dir_ready=0 -> exactly one entry, dir_out=3, dir_valid rising 2 clocks after first sample, fifo_count=1.
- PS2 bytes E0,75 then E0,F0,75 then 1C -> FIFO holds UP, LEFT in order (release ignored). A stray 0x5A produces nothing.
- Keypad LEFT and PS2 byte 23 events in the same cycle, reset RR -> FIFO order LEFT, RIGHT. A repeat of both in the same cycle -> RIGHT first.
- DEPTH=4, dir_ready=0, 6 keypad events -> fifo_count=4, overflow=1. Then dir_ready=1 drains 4 commands in order. clr_ovf=1 -> overflow=0.
- With DIR_FILTER_EN: UP, UP, DOWN, UP -> FIFO holds UP, DOWN, UP.
- Without DIR_FILTER_EN: UP, UP, DOWN, UP -> all 4 entries pushed.

Source files
------------

// File: rtl/dir_cmd_arbiter.sv
// dir_cmd_arbiter
// Merges keypad scanner and PS2 keyboard inputs into one ordered stream of
// 2-bit Pacman direction commands (0=UP, 1=DOWN, 2=LEFT, 3=RIGHT).
// Each source: rising-level event detect -> decode -> one-entry pending slot.
// The pending slots are arbitrated round-robin into a DEPTH-entry FIFO, and
// the FIFO is popped through a valid/ready handshake.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   key_code, key_ready   keypad scanner code and level-valid
//   ps2_byte, ps2_ready   PS2 receiver byte and level-valid
//   dir_out, dir_valid    FIFO head direction and non-empty flag
//   dir_ready             consumer pop strobe
//   last_dir              last popped direction
//   fifo_count            FIFO occupancy
//   overflow, clr_ovf     sticky pending-overwrite flag and its clear
//
// Build option:
//   DIR_FILTER_EN  drop a pending direction equal to the last pushed one.

module dir_cmd_arbiter #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [4:0]  KP_UP    = 5'h01,
   parameter logic [4:0]  KP_DOWN  = 5'h09,
   parameter logic [4:0]  KP_LEFT  = 5'h04,
   parameter logic [4:0]  KP_RIGHT = 5'h06
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [4:0]               key_code,
   input  logic                     key_ready,
   input  logic [7:0]               ps2_byte,
   input  logic                     ps2_ready,
   output logic [1:0]               dir_out,
   output logic                     dir_valid,
   input  logic                     dir_ready,
   output logic [1:0]               last_dir,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow,
   input  logic                     clr_ovf
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   typedef enum logic [1:0] {
      PS_IDLE = 2'd0,
      PS_EXT  = 2'd1,
      PS_BRK  = 2'd2
   } ps_state_t;

   // Edge detect: an event needs a low sample since reset, so a level
   // already high when reset releases produces nothing.
   logic kp_seen_low, ps_seen_low;
   logic kp_evt_c, ps_evt_c;

   assign kp_evt_c = key_ready & kp_seen_low;
   assign ps_evt_c = ps2_ready & ps_seen_low;

   // Keypad code decode
   logic       kp_hit_c;
   logic [1:0] kp_dir_c;

   always_comb begin
      kp_hit_c = 1'b1;
      kp_dir_c = DIR_UP;
      if (key_code == KP_UP)         kp_dir_c = DIR_UP;
      else if (key_code == KP_DOWN)  kp_dir_c = DIR_DOWN;
      else if (key_code == KP_LEFT)  kp_dir_c = DIR_LEFT;
      else if (key_code == KP_RIGHT) kp_dir_c = DIR_RIGHT;
      else                           kp_hit_c = 1'b0;
   end

   // PS2 scan-code decoder: state register
   ps_state_t ps_state, ps_state_n;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ps_state <= PS_IDLE;
      else      ps_state <= ps_state_n;
   end

   // PS2 scan-code decoder: next state and emitted direction
   logic       ps_hit_c;
   logic [1:0] ps_dir_c;

   always_comb begin
      ps_state_n = ps_state;
      ps_hit_c   = 1'b0;
      ps_dir_c   = DIR_UP;
      if (ps_evt_c) begin
         case (ps_state)
            PS_IDLE: begin
               case (ps2_byte)
                  8'hE0:   ps_state_n = PS_EXT;
                  8'hF0:   ps_state_n = PS_BRK;
                  8'h1D:   begin ps_hit_c = 1'b1; ps_dir_c = DIR_UP;    end
                  8'h1B:   begin ps_hit_c = 1'b1; ps_dir_c = DIR_DOWN;  end
                  8'h1C:   begin ps_hit_c = 1'b1; ps_dir_c = DIR_LEFT;  end
                  8'h23:   begin ps_hit_c = 1'b1; ps_dir_c = DIR_RIGHT; end
                  default: ps_state_n = PS_IDLE;
               endcase
            end
            PS_EXT: begin
               ps_state_n = PS_IDLE;
               case (ps2_byte)
                  8'hF0:   ps_state_n = PS_BRK;
                  8'h75:   begin ps_hit_c = 1'b1; ps_dir_c = DIR_UP;    end
                  8'h72:   begin ps_hit_c = 1'b1; ps_dir_c = DIR_DOWN;  end
                  8'h6B:   begin ps_hit_c = 1'b1; ps_dir_c = DIR_LEFT;  end
                  8'h74:   begin ps_hit_c = 1'b1; ps_dir_c = DIR_RIGHT; end
                  default: ps_state_n = PS_IDLE;
               endcase
            end
            PS_BRK:  ps_state_n = PS_IDLE;
            default: ps_state_n = PS_IDLE;
         endcase
      end
   end

   // Event stage: level history and the decoded direction of this event
   logic       kp_new_v, ps_new_v;
   logic [1:0] kp_new_d, ps_new_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         kp_seen_low <= 1'b0;
         ps_seen_low <= 1'b0;
         kp_new_v    <= 1'b0;
         kp_new_d    <= DIR_UP;
         ps_new_v    <= 1'b0;
         ps_new_d    <= DIR_UP;
      end else begin
         kp_seen_low <= ~key_ready;
         ps_seen_low <= ~ps2_ready;
         kp_new_v    <= kp_evt_c & kp_hit_c;
         kp_new_d    <= kp_dir_c;
         ps_new_v    <= ps_hit_c;
         ps_new_d    <= ps_dir_c;
      end
   end

   // Arbitration between the two pending slots
   logic       kp_pend_v, ps_pend_v;
   logic [1:0] kp_pend_d, ps_pend_d;
   logic       rr_ps2;
   logic       pop_c, space_c, any_c, sel_ps2_c, drop_c;
   logic       grant_c, push_c, kp_grant_c, ps_grant_c;
   logic [1:0] sel_dir_c;

   assign pop_c      = dir_valid & dir_ready;
   assign space_c    = (fifo_count != CW'(DEPTH)) | pop_c;
   assign any_c      = kp_pend_v | ps_pend_v;
   assign sel_ps2_c  = ps_pend_v & (~kp_pend_v | rr_ps2);
   assign sel_dir_c  = sel_ps2_c ? ps_pend_d : kp_pend_d;
   assign grant_c    = any_c & (space_c | drop_c);
   assign push_c     = grant_c & ~drop_c;
   assign kp_grant_c = grant_c & ~sel_ps2_c;
   assign ps_grant_c = grant_c & sel_ps2_c;

`ifdef DIR_FILTER_EN
   // Repeat filter: reference is the last direction actually pushed
   logic       last_push_v;
   logic [1:0] last_push_d;

   assign drop_c = last_push_v & (sel_dir_c == last_push_d);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_push_v <= 1'b0;
         last_push_d <= DIR_UP;
      end else if (push_c) begin
         last_push_v <= 1'b1;
         last_push_d <= sel_dir_c;
      end
   end
`else
   assign drop_c = 1'b0;
`endif

   // Pending slots, round-robin pointer and sticky overflow
   logic ovf_set_c;

   assign ovf_set_c = (kp_new_v & kp_pend_v & ~kp_grant_c) |
                      (ps_new_v & ps_pend_v & ~ps_grant_c);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         kp_pend_v <= 1'b0;
         kp_pend_d <= DIR_UP;
         ps_pend_v <= 1'b0;
         ps_pend_d <= DIR_UP;
         rr_ps2    <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (kp_new_v) begin
            kp_pend_v <= 1'b1;
            kp_pend_d <= kp_new_d;
         end else if (kp_grant_c) begin
            kp_pend_v <= 1'b0;
         end
         if (ps_new_v) begin
            ps_pend_v <= 1'b1;
            ps_pend_d <= ps_new_d;
         end else if (ps_grant_c) begin
            ps_pend_v <= 1'b0;
         end
         // Pointer only moves after a grant that had a real contender
         if (grant_c & kp_pend_v & ps_pend_v) rr_ps2 <= ~rr_ps2;
         if (ovf_set_c)    overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

   // FIFO storage and next-head selection
   logic [1:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_p1_c;
   logic [CW-1:0] count_n_c;
   logic [1:0]    head_n_c;

   assign rd_ptr_p1_c = PW'(rd_ptr + 1'b1);
   assign count_n_c   = fifo_count + CW'(push_c) - CW'(pop_c);

   // dir_out is registered, so the new head is computed one edge early
   always_comb begin
      head_n_c = dir_out;
      if (pop_c) begin
         if (fifo_count == CW'(1)) begin
            if (push_c) head_n_c = sel_dir_c;
         end else begin
            head_n_c = mem[rd_ptr_p1_c];
         end
      end else if (push_c && (fifo_count == CW'(0))) begin
         head_n_c = sel_dir_c;
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= sel_dir_c;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         dir_valid  <= 1'b0;
         dir_out    <= DIR_UP;
         last_dir   <= DIR_UP;
      end else begin
         if (push_c) wr_ptr <= PW'(wr_ptr + 1'b1);
         if (pop_c) begin
            rd_ptr   <= rd_ptr_p1_c;
            last_dir <= dir_out;
         end
         fifo_count <= count_n_c;
         dir_valid  <= (count_n_c != CW'(0));
         dir_out    <= head_n_c;
      end
   end

endmodule
